// File: rtl/tdm_demux64.sv
// tdm_demux64: registered 1-to-N time-division demultiplexer.
// Walks the select lines of an upstream N:1 mux and samples its serial
// output on every accepted beat (din_valid = 1). The sampled bits are
// rebuilt in a shadow register and, once the last channel is taken, the
// whole word is presented on frame with a valid/ack handshake.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        begin a scan (honoured in IDLE, or in HOLD with frame_ack)
//   din          serial bit from the upstream mux
//   din_valid    din is valid for channel sel_out this cycle
//   sel_out      channel select driven to the upstream mux
//   busy         scan in progress
//   frame        last completed frame, bit k = sample taken at sel_out == k
//   frame_valid  frame holds new, unacknowledged data
//   frame_ack    consumer accepts frame (effective only while frame_valid)
//   parity_err   parity check result (only with TDM_DEMUX_PARITY_EN)
//
// Optional feature macro: TDM_DEMUX_PARITY_EN adds a trailing even-parity
// beat after channel N-1, a PARITY state and the parity_err output.
module tdm_demux64 #(
  parameter int unsigned N     = 64,
  parameter int unsigned SEL_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [SEL_W-1:0] sel_out,
  output logic             busy,
  output logic [N-1:0]     frame,
  output logic             frame_valid,
`ifdef TDM_DEMUX_PARITY_EN
  output logic             parity_err,
`endif
  input  logic             frame_ack
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2,
    PARITY = 2'd3
  } state_t;

  state_t         state;
  logic [N-1:0]   shadow;
  logic [N-1:0]   shadow_nxt;

  // Shadow word with the current sample merged in; lets the completing
  // beat write frame including its own bit in the same edge.
  always_comb begin
    shadow_nxt          = shadow;
    shadow_nxt[sel_out] = din;
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel_out     <= '0;
      busy        <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      shadow      <= '0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          sel_out <= '0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end

        SCAN: begin
          // din_valid = 0 is a stall: select and shadow hold, no timeout.
          if (din_valid) begin
            shadow <= shadow_nxt;
            if (sel_out == LAST_SEL) begin
`ifdef TDM_DEMUX_PARITY_EN
              // Select stays at N-1 while the parity beat is awaited.
              state <= PARITY;
`else
              state       <= HOLD;
              frame       <= shadow_nxt;
              frame_valid <= 1'b1;
              busy        <= 1'b0;
              sel_out     <= '0;
`endif
            end else begin
              sel_out <= sel_out + SEL_W'(1);
            end
          end
        end

`ifdef TDM_DEMUX_PARITY_EN
        PARITY: begin
          // Even parity: data bits XOR parity bit must be zero.
          if (din_valid) begin
            state       <= HOLD;
            frame       <= shadow;
            frame_valid <= 1'b1;
            parity_err  <= (^shadow) ^ din;
            busy        <= 1'b0;
            sel_out     <= '0;
          end
        end
`endif

        HOLD: begin
          // Frame is protected until acknowledged; start alone is ignored.
          if (frame_ack) begin
            frame_valid <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (start) begin
              state <= SCAN;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          sel_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux64.sv
// tb_tdm_demux64: randomized self-checking bench for tdm_demux64.
// The reference is a word-level model: the expected frame is the word the
// bench serialises, and the expected select is the number of beats the
// bench has had accepted so far.
module tb_tdm_demux64;

  localparam int unsigned N     = 64;
  localparam int unsigned SEL_W = 6;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int PAR_BEATS = 1;
`else
  localparam int PAR_BEATS = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             din;
  logic             din_valid;
  logic [SEL_W-1:0] sel_out;
  logic             busy;
  logic [N-1:0]     frame;
  logic             frame_valid;
  logic             frame_ack;
`ifdef TDM_DEMUX_PARITY_EN
  logic             parity_err;
`endif

  int checks;
  int errors;

  tdm_demux64 #(.N(N), .SEL_W(SEL_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .din         (din),
    .din_valid   (din_valid),
    .sel_out     (sel_out),
    .busy        (busy),
    .frame       (frame),
    .frame_valid (frame_valid),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .frame_ack   (frame_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},   64'(sel_out), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_frame"}, 64'(frame), 64'd0);
    check({tag, "_fv"},    64'(frame_valid), 64'd0);
`ifdef TDM_DEMUX_PARITY_EN
    check({tag, "_perr"},  64'(parity_err), 64'd0);
`endif
  endtask

  // Issue start from IDLE; DUT must be in SCAN at channel 0 afterwards.
  task automatic begin_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_sel",  64'(sel_out), 64'd0);
    check("start_fv",   64'(frame_valid), 64'd0);
  endtask

  // Serialise word (plus parity bit if compiled in). mode 0: no stalls,
  // 1: valid toggles 1,0,1,0..., 2: random stalls. abort_at >= 0 drops
  // rst_n right after that many beats were accepted.
  task automatic scan_frame(input logic [63:0] word, input int mode, input logic pbit,
                            input int abort_at, output int cycles);
    int idx;
    int need;
    idx    = 0;
    cycles = 0;
    need   = N + PAR_BEATS;
    while (idx < need && cycles < 8 * N) begin
      case (mode)
        0:       din_valid = 1'b1;
        1:       din_valid = (cycles % 2 == 0);
        default: din_valid = ($urandom_range(0, 2) != 0);
      endcase
      din       = (idx < N) ? word[idx] : pbit;
      start     = 1'($urandom_range(0, 1));   // ignored during a scan
      frame_ack = 1'($urandom_range(0, 1));   // no effect outside HOLD
      tick();
      cycles++;
      if (din_valid) idx++;
      if (idx < need) begin
        check("scan_sel",  64'(sel_out), (idx < N) ? 64'(idx) : 64'(N - 1));
        check("scan_busy", 64'(busy), 64'd1);
        check("scan_fv",   64'(frame_valid), 64'd0);
      end
      if (abort_at >= 0 && idx == abort_at) begin
        start = 1'b0; frame_ack = 1'b0; din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        return;
      end
    end
    start = 1'b0; frame_ack = 1'b0; din_valid = 1'b0;
    if (idx < need) check("scan_timeout", 64'(idx), 64'(need));
    check("done_fv",    64'(frame_valid), 64'd1);
    check("done_frame", 64'(frame), word);
    check("done_busy",  64'(busy), 64'd0);
    check("done_sel",   64'(sel_out), 64'd0);
`ifdef TDM_DEMUX_PARITY_EN
    check("done_perr",  64'(parity_err), 64'((^word) ^ pbit));
`endif
  endtask

  // Acknowledge the held frame, optionally starting the next scan at once.
  task automatic ack_frame(input logic next_start, input logic [63:0] word);
    frame_ack = 1'b1;
    start     = next_start;
    tick();
    frame_ack = 1'b0;
    start     = 1'b0;
    check("ack_fv",    64'(frame_valid), 64'd0);
    check("ack_busy",  64'(busy), 64'(next_start));
    check("ack_sel",   64'(sel_out), 64'd0);
    check("ack_frame", 64'(frame), word);
`ifdef TDM_DEMUX_PARITY_EN
    check("ack_perr",  64'(parity_err), 64'd0);
`endif
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] wa;
    logic [63:0] wb;
    logic        pb;
    logic        b2b;
    int          cyc;

    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; din = 1'b0; din_valid = 1'b0; frame_ack = 1'b0;

    // Reset, then idle with start low.
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame_ack = 1'($urandom_range(0, 1));
      din_valid = 1'($urandom_range(0, 1));
      din       = 1'($urandom_range(0, 1));
      tick();
      check_reset_outputs("idle");
    end
    frame_ack = 1'b0; din_valid = 1'b0;

    // Walking one at channel 5, no stalls.
    w = 64'h0000_0000_0000_0020;
    pb = ^w;
    begin_scan();
    scan_frame(w, 0, pb, -1, cyc);
    check("walk_latency", 64'(cyc), 64'(N + PAR_BEATS));
    ack_frame(1'b0, w);

    // Same frame with valid toggling 1,0,1,0.
    begin_scan();
    scan_frame(w, 1, pb, -1, cyc);
    check("stall_latency", 64'(cyc), 64'(2 * (N + PAR_BEATS) - 1));

    // Frame cannot be overwritten before ack; start-without-ack ignored.
    ack_frame(1'b1, w);
    wa = 64'hDEAD_BEEF_0123_4567;
    scan_frame(wa, 0, ^wa, -1, cyc);
    for (int i = 0; i < 5; i++) begin
      start     = 1'b1;
      din_valid = 1'b1;
      din       = 1'($urandom_range(0, 1));
      tick();
      check("hold_frame", 64'(frame), wa);
      check("hold_fv",    64'(frame_valid), 64'd1);
      check("hold_busy",  64'(busy), 64'd0);
    end
    start = 1'b0; din_valid = 1'b0;
    wb = 64'hFFFF_FFFF_FFFF_FFFF;
    ack_frame(1'b1, wa);
    scan_frame(wb, 2, ^wb, -1, cyc);
    ack_frame(1'b0, wb);

    // Asynchronous reset in the middle of a scan.
    begin_scan();
    scan_frame(64'h0123_4567_89AB_CDEF, 0, 1'b0, 37, cyc);
    tick();
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    tick();
    w = 64'hA5A5_A5A5_A5A5_A5A5;
    begin_scan();
    scan_frame(w, 2, ^w, -1, cyc);
    ack_frame(1'b0, w);

    // Randomized frames, mixed back-to-back and idle gaps.
    b2b = 1'b0;
    for (int f = 0; f < 6; f++) begin
      w  = {$urandom(), $urandom()};
      pb = ^w;
      if (!b2b) begin_scan();
      scan_frame(w, (f % 3), pb, -1, cyc);
      b2b = 1'($urandom_range(0, 1));
      ack_frame(b2b, w);
    end
    if (b2b) begin
      w = {$urandom(), $urandom()};
      scan_frame(w, 0, ^w, -1, cyc);
      ack_frame(1'b0, w);
    end

`ifdef TDM_DEMUX_PARITY_EN
    // Correct even parity, then a corrupted parity bit.
    w = 64'h1;
    begin_scan();
    scan_frame(w, 0, 1'b1, -1, cyc);
    check("par_ok", 64'(parity_err), 64'd0);
    ack_frame(1'b0, w);
    begin_scan();
    scan_frame(w, 0, 1'b0, -1, cyc);
    check("par_bad", 64'(parity_err), 64'd1);
    ack_frame(1'b0, w);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux64.md
Name: tdm_demux64

Overview:
- Registered 1-to-64 time-division demultiplexer; the receive end of the 64:1 mux datapath.
- Drives the select lines of the upstream mux and samples its serial output bit each accepted cycle.
- Rebuilds the 64-bit word in a shadow register and presents it as a complete frame with a valid/ack handshake.
- Sits between the upstream mux and frame-level consumer logic.

Parameters:
- N, 64, number of channels per frame; power of two, at least 2.
- SEL_W, 6, select width; must equal log2(N).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a frame scan; sampled only in IDLE, or in HOLD together with frame_ack.
- din  input  1  serial bit from the upstream mux output.
- din_valid  input  1  din is valid this cycle for channel sel_out.
- sel_out  output  SEL_W  channel select driven to the upstream mux.
- busy  output  1  high in SCAN (and PARITY when the optional feature is compiled in).
- frame  output  N  last completed frame; bit k = value sampled while sel_out == k.
- frame_valid  output  1  frame holds new, unacknowledged data.
- frame_ack  input  1  consumer accepts frame; effective only while frame_valid = 1.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, sel_out = 0, busy = 0, frame = 0, frame_valid = 0, shadow = 0.
  - Applies immediately, including mid-scan; the partial frame is discarded.
- States: IDLE, SCAN, HOLD (plus PARITY with the optional feature).
- IDLE:
  - sel_out = 0.
  - start = 1 -> SCAN next cycle, sel_out = 0, busy = 1.
- SCAN:
  - Each cycle with din_valid = 1: shadow[sel_out] <= din.
  - If sel_out < N-1: sel_out increments by 1.
  - If sel_out == N-1 and din_valid = 1 -> HOLD: frame <= shadow including this bit, frame_valid <= 1, busy <= 0, sel_out <= 0 (wraps, never exceeds N-1).
  - din_valid = 0 -> stall: sel_out and shadow unchanged, no timeout.
  - start is ignored.
- Latency: a frame with no stalls completes N cycles after SCAN entry. frame_valid rises on the edge that captures bit N-1.
- HOLD:
  - frame and frame_valid are stable.
  - din and din_valid are ignored.
  - frame_ack = 1 -> frame_valid <= 0 next edge.
    - With start = 0 in the same cycle -> IDLE.
    - With start = 1 in the same cycle -> SCAN directly; back-to-back frames need no idle cycle.
  - start without frame_ack is ignored; the frame cannot be overwritten before ack.
- frame_ack outside HOLD has no effect.
- frame keeps its last value after ack until the next frame completes.
- shadow is not cleared between frames; every bit is rewritten each scan.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - After bit N-1 is accepted, the FSM enters PARITY (busy = 1, sel_out held at N-1) and waits for one more din_valid beat carrying an even-parity bit.
  - Adds output parity_err (1 bit, reset 0). On that beat: frame <= shadow, frame_valid <= 1, parity_err <= (XOR of the N data bits) XOR din, then -> HOLD.
  - parity_err is cleared together with frame_valid on ack.
  - Latency becomes N+1 accepted beats.
- Undefined:
  - No PARITY state and no parity_err port.
  - Behaviour exactly as described above.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, release, start = 0 for 10 cycles -> sel_out = 0, busy = 0, frame = 0, frame_valid = 0 throughout.
- Walking-one frame: start pulse, din = (sel_out == 5) with din_valid = 1 for 64 cycles -> frame_valid rises 64 cycles after SCAN entry with frame = 64'h0000_0000_0000_0020; sel_out stepped 0..63 then returned to 0.
- Stalls: same pattern as the walking-one frame with din_valid toggled 1,0,1,0 -> sel_out holds during the 0 cycles, completion at cycle 127 of SCAN, frame identical to the unstalled run.
- Hold and back-to-back:
  - Complete frame A = 64'hDEAD_BEEF_0123_4567.
  - Assert start without ack for 5 cycles -> frame unchanged, frame_valid stays 1.
  - Then assert ack and start in the same cycle -> frame_valid = 0 next cycle, busy = 1, second frame B = 64'hFFFF_FFFF_FFFF_FFFF captured correctly.
- Reset mid-scan: drop rst_n at sel_out = 37 -> all outputs return to reset values asynchronously (before the next edge); a fresh scan afterwards yields a correct frame of 64'hA5A5_A5A5_A5A5_A5A5.
- With TDM_DEMUX_PARITY_EN:
  - Frame 64'h1 with parity bit 1 -> parity_err = 0.
  - Same frame with parity bit 0 -> parity_err = 1 alongside frame_valid, cleared on ack.
